// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered N-to-NUM_OUT one-hot decoder with a select
// handshake and an auto-scan (walking-one) mode that has a programmable
// step rate and a wrap pulse.
// Optional feature: define DEC_ERR_EN to add the 'err' port.
// 'err' pulses for one cycle after DECODE samples an illegal code.
module decoder_n_scan #(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap
`ifdef DEC_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_OUT-1:0]   y_q, y_d;
  logic [NUM_OUT-1:0]   y_dec;
  logic                 y_valid_q, y_valid_d;
  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic                 wrap_q, wrap_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
`ifdef DEC_ERR_EN
  logic                 err_q, err_d;
`endif

  // One-hot image of the next index; cur_sel_d never leaves 0..NUM_OUT-1.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
    assign y_dec[gi] = (cur_sel_d == SEL_W'(gi));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: enable dominates, otherwise mode picks DECODE or SCAN.
  always_comb begin
    state_d = state_q;
    if (!en)       state_d = ST_IDLE;
    else if (mode) state_d = ST_SCAN;
    else           state_d = ST_DECODE;
  end

  // Output/datapath next values for the registered outputs.
  always_comb begin
    cur_sel_d = cur_sel_q;
    div_cnt_d = '0;
    wrap_d    = 1'b0;
    y_valid_d = 1'b0;
`ifdef DEC_ERR_EN
    err_d     = 1'b0;
`endif
    if (!en) begin
      y_valid_d = 1'b0;
    end else if (mode) begin
      y_valid_d = 1'b1;
      if (state_q != ST_SCAN) begin
        // Fresh scan always restarts at bit 0 with the divider cleared.
        cur_sel_d = '0;
      end else if (div_cnt_q == DIV_LAST) begin
        // Step, wrapping modulo NUM_OUT rather than 2**SEL_W.
        if (cur_sel_q == SEL_LAST) begin
          cur_sel_d = '0;
          wrap_d    = 1'b1;
        end else begin
          cur_sel_d = cur_sel_q + 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end else begin
      // DECODE: output holds unless a new code arrives.
      y_valid_d = y_valid_q;
      if (sel_valid) begin
        if ({1'b0, sel} < NUM_OUT_W) begin
          cur_sel_d = sel;
          y_valid_d = 1'b1;
        end else begin
          y_valid_d = 1'b0;
`ifdef DEC_ERR_EN
          err_d     = 1'b1;
`endif
        end
      end
    end
    y_d = y_valid_d ? y_dec : '0;
  end

  // Output and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      cur_sel_q <= '0;
      wrap_q    <= 1'b0;
      div_cnt_q <= '0;
`ifdef DEC_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      cur_sel_q <= cur_sel_d;
      wrap_q    <= wrap_d;
      div_cnt_q <= div_cnt_d;
`ifdef DEC_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign cur_sel = cur_sel_q;
  assign wrap    = wrap_q;
`ifdef DEC_ERR_EN
  assign err     = err_q;
`endif

endmodule

// File: tb/tb_decoder_n_scan.sv
// Bench for decoder_n_scan: two instances (8 outputs / step 4, and
// 6 outputs / step 1) share stimulus; a behavioural model tracks both.
module tb_decoder_n_scan;

  localparam int N0 = 8, D0 = 4;
  localparam int N1 = 6, D1 = 1;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, sel_valid;
  logic [2:0] sel;
  logic [7:0] y0;
  logic [5:0] y1;
  logic       yv0, yv1, w0, w1;
  logic [2:0] cs0, cs1;
`ifdef DEC_ERR_EN
  logic       e0, e1;
`endif

  always #5 clk = ~clk;

  decoder_n_scan #(.SEL_W(3), .NUM_OUT(N0), .SCAN_DIV(D0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .y(y0), .y_valid(yv0), .cur_sel(cs0), .wrap(w0)
`ifdef DEC_ERR_EN
    , .err(e0)
`endif
  );

  decoder_n_scan #(.SEL_W(3), .NUM_OUT(N1), .SCAN_DIV(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .y(y1), .y_valid(yv1), .cur_sel(cs1), .wrap(w1)
`ifdef DEC_ERR_EN
    , .err(e1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: scan position derived from cycles spent in SCAN.
  int m_n   [2] = '{N0, N1};
  int m_div [2] = '{D0, D1};
  int m_st  [2];   // 0 idle, 1 decode, 2 scan
  int m_act [2];
  int m_cur [2];
  int m_age [2];
  int m_wrap[2];
  int m_err [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_act[i] = 0; m_cur[i] = 0;
      m_age[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step(input logic e, input logic m, input logic v, input int s);
    for (int i = 0; i < 2; i++) begin
      m_wrap[i] = 0;
      m_err[i]  = 0;
      if (!e) begin
        m_st[i] = 0; m_act[i] = 0;
      end else if (m) begin
        if (m_st[i] != 2) m_age[i] = 0;
        else              m_age[i] = m_age[i] + 1;
        m_st[i]   = 2;
        m_act[i]  = 1;
        m_cur[i]  = (m_age[i] / m_div[i]) % m_n[i];
        m_wrap[i] = (m_age[i] > 0 && (m_age[i] % (m_div[i] * m_n[i])) == 0) ? 1 : 0;
      end else begin
        m_st[i] = 1;
        if (v) begin
          if (s < m_n[i]) begin m_cur[i] = s; m_act[i] = 1; end
          else begin m_act[i] = 0; m_err[i] = 1; end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_y(input int i);
    return m_act[i] ? (32'd1 << m_cur[i]) : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("y0",  32'(y0),  exp_y(0));
    chk("yv0", 32'(yv0), 32'(m_act[0]));
    chk("cs0", 32'(cs0), 32'(m_cur[0]));
    chk("w0",  32'(w0),  32'(m_wrap[0]));
    chk("y1",  32'(y1),  exp_y(1));
    chk("yv1", 32'(yv1), 32'(m_act[1]));
    chk("cs1", 32'(cs1), 32'(m_cur[1]));
    chk("w1",  32'(w1),  32'(m_wrap[1]));
`ifdef DEC_ERR_EN
    chk("e0",  32'(e0),  32'(m_err[0]));
    chk("e1",  32'(e1),  32'(m_err[1]));
`endif
  endtask

  // Apply one input set across a rising edge, then check just after it.
  task automatic tick(input logic e, input logic m, input logic v, input logic [2:0] s);
    en = e; mode = m; sel_valid = v; sel = s;
    @(posedge clk);
    model_step(e, m, v, int'(s));
    #1;
    check_model();
    $display("t=%0t en=%0b mode=%0b sv=%0b sel=%0d | y0=%h cs0=%0d w0=%b | y1=%h cs1=%0d w1=%b",
             $time, e, m, v, s, y0, cs0, w0, y1, cs1, w1);
    @(negedge clk);
  endtask

  typedef struct {
    logic       en, mode, sv;
    logic [2:0] sel;
    logic [7:0] ey;
    logic       eyv;
    logic [2:0] ecs;
  } vec_t;

  vec_t tbl [11];
  int   wcnt;
  logic mode_r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 3'd5};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd3, 8'h20, 1'b1, 3'd5};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h20, 1'b1, 3'd5};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd7, 8'h20, 1'b1, 3'd5};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 3'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 3'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 3'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 3'd7};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 3'd3, 8'h01, 1'b1, 3'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0};

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors against fixed expectations for the 8-output instance.
    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].mode, tbl[i].sv, tbl[i].sel);
      chk("tbl_y",  32'(y0),  32'(tbl[i].ey));
      chk("tbl_yv", 32'(yv0), 32'(tbl[i].eyv));
      chk("tbl_cs", 32'(cs0), 32'(tbl[i].ecs));
    end

    // Illegal code on the 6-output instance clears y and holds cur_sel.
    tick(1, 0, 1, 3'd3);
    chk("ill_pre_y1", 32'(y1), 32'h08);
    tick(1, 0, 1, 3'd7);
    chk("ill_y1",  32'(y1),  32'h00);
    chk("ill_yv1", 32'(yv1), 32'h0);
    chk("ill_cs1", 32'(cs1), 32'd3);
    chk("ill_y0",  32'(y0),  32'h80);
`ifdef DEC_ERR_EN
    chk("ill_err1", 32'(e1), 32'h1);
`endif
    tick(1, 0, 0, 3'd0);
    chk("ill_hold_y1", 32'(y1), 32'h00);
`ifdef DEC_ERR_EN
    chk("ill_err1_clr", 32'(e1), 32'h0);
`endif

    // Full scan with wrap counting on the 8-output / step-4 instance.
    tick(1, 1, 0, 3'd0);
    chk("scan_entry_y0", 32'(y0), 32'h01);
    wcnt = 0;
    for (int k = 1; k <= 64; k++) begin
      tick(1, 1, 1, 3'($urandom_range(0, 7)));
      if (w0) wcnt++;
      chk("scan_walk_y0", 32'(y0), 32'd1 << ((k / 4) % 8));
    end
    chk("wrap_count", 32'(wcnt), 32'd2);

    // Step-1 scan dropped at index 3, then restarted.
    tick(1, 0, 0, 3'd0);
    tick(1, 1, 0, 3'd0);
    repeat (3) tick(1, 1, 0, 3'd0);
    chk("div1_cs1", 32'(cs1), 32'd3);
    chk("div1_y1",  32'(y1),  32'h08);
    tick(0, 1, 0, 3'd0);
    chk("div1_off_y1",  32'(y1),  32'h00);
    chk("div1_off_yv1", 32'(yv1), 32'h0);
    chk("div1_off_cs1", 32'(cs1), 32'd3);
    tick(1, 1, 0, 3'd0);
    chk("div1_restart_y1", 32'(y1), 32'h01);

    // SCAN -> DECODE at index 2 with a code in the same cycle.
    tick(1, 0, 0, 3'd0);
    tick(1, 1, 0, 3'd0);
    repeat (8) tick(1, 1, 0, 3'd0);
    chk("s2d_pre_cs0", 32'(cs0), 32'd2);
    tick(1, 0, 1, 3'd6);
    chk("s2d_y0",  32'(y0),  32'h40);
    chk("s2d_w0",  32'(w0),  32'h0);
    chk("s2d_cs0", 32'(cs0), 32'd6);

    // Asynchronous reset in the middle of a scan with y0 = 8'h10.
    tick(1, 0, 0, 3'd0);
    tick(1, 1, 0, 3'd0);
    repeat (16) tick(1, 1, 0, 3'd0);
    chk("arst_pre_y0", 32'(y0), 32'h10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    chk("arst_y0",  32'(y0),  32'h00);
    chk("arst_cs0", 32'(cs0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    mode_r = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
      tick(($urandom_range(0, 15) != 0), mode_r, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
